// File: rtl/tdm_demux4_rx.sv
// Four-channel TDM receiver: locks to a frame-sync strobe, deserialises W-bit
// MSB-first slots and writes each completed word to its channel register.
module tdm_demux4_rx #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           bit_en,
    input  logic           din,
    input  logic           sync,
    output logic [4*W-1:0] ch_data,
    output logic [3:0]     ch_valid,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);

    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]     slot_cnt_q, slot_cnt_d;
    logic [W-2:0]   shift_q, shift_d;
    logic [4*W-1:0] ch_data_q, ch_data_d;
    logic [3:0]     ch_valid_q, ch_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           sync_err_q, sync_err_d;
    logic           locked_q, locked_d;

    logic [W-1:0]   word;
    logic           at_boundary;

    assign word        = {shift_q, din};
    assign at_boundary = (bit_cnt_q == '0) && (slot_cnt_q == 2'd0);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        shift_d      = shift_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = 4'b0000;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (sync) begin
                        state_d    = RUN;
                        bit_cnt_d  = CW'(1);
                        slot_cnt_d = 2'd0;
                        shift_d    = word[W-2:0];
                    end
                end
                RUN: begin
                    if (at_boundary && !sync) begin
                        // Lost frame alignment: drop back to hunting, discard this bit.
                        sync_err_d = 1'b1;
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        slot_cnt_d = 2'd0;
                    end else if (sync && !at_boundary) begin
                        // Misplaced sync re-frames on this bit; partial word is lost.
                        sync_err_d = 1'b1;
                        bit_cnt_d  = CW'(1);
                        slot_cnt_d = 2'd0;
                        shift_d    = word[W-2:0];
                    end else begin
                        shift_d = word[W-2:0];
                        if (bit_cnt_q == CW'(W-1)) begin
                            for (int k = 0; k < 4; k++) begin
                                if (slot_cnt_q == 2'(k)) begin
                                    ch_data_d[k*W +: W] = word;
                                end
                            end
                            ch_valid_d[slot_cnt_q] = 1'b1;
                            frame_done_d           = (slot_cnt_q == 2'd3);
                            bit_cnt_d              = '0;
                            slot_cnt_d             = slot_cnt_q + 2'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= 2'd0;
            shift_q      <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= 4'b0000;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
        end
    end

    assign ch_data    = ch_data_q;
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// Scoreboard bench for tdm_demux4_rx: the driver queues hand-computed output
// events tagged with the clock edge that should produce them; a monitor pops them.
module tb_tdm_demux4_rx;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          bit_en;
    logic          din;
    logic          sync;
    logic [4*W-1:0] ch_data;
    logic [3:0]    ch_valid;
    logic          frame_done;
    logic          sync_err;
    logic          locked;

    tdm_demux4_rx #(.W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bit_en     (bit_en),
        .din        (din),
        .sync       (sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        logic [3:0]  v;
        logic        fd;
        logic        se;
        logic [31:0] data;
        logic        lk;
    } evt_t;

    evt_t q[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every cycle with any pulse must match the next queued event.
    always @(negedge clk) begin
        if (mon_en && ((ch_valid != 4'b0) || frame_done || sync_err)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual v=%b fd=%b se=%b required none (edge %0d)",
                         ch_valid, frame_done, sync_err, edge_cnt);
            end else begin
                evt_t e;
                e = q.pop_front();
                chk("evt_edge",   32'(edge_cnt),   32'(e.edge_no));
                chk("ch_valid",   32'(ch_valid),   32'(e.v));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("sync_err",   32'(sync_err),   32'(e.se));
                chk("ch_data",    ch_data,         e.data);
                chk("locked",     32'(locked),     32'(e.lk));
            end
        end
    end

    // Queue an event produced by the edge the next drive() call reaches.
    task automatic expect_evt(input logic [3:0] v, input logic fd, input logic se,
                              input logic [31:0] data, input logic lk);
        evt_t e;
        e.edge_no = edge_cnt + 1;
        e.v       = v;
        e.fd      = fd;
        e.se      = se;
        e.data    = data;
        e.lk      = lk;
        q.push_back(e);
    endtask

    task automatic drive(input logic en, input logic s, input logic d);
        bit_en = en;
        sync   = s;
        din    = d;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles carry sync=1 and inverted data to prove they are ignored.
    task automatic gaps(input int n, input logic d);
        for (int g = 0; g < n; g++) drive(1'b0, 1'b1, ~d);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic s_first, input int gap);
        for (int i = 0; i < n; i++) begin
            gaps(gap, b[7-i]);
            drive(1'b1, (i == 0) ? s_first : 1'b0, b[7-i]);
        end
    endtask

    task automatic send_slot(input logic [7:0] b, input logic s_first, input logic [3:0] v,
                             input logic fd, input logic [31:0] data, input int gap);
        for (int i = 0; i < 8; i++) begin
            gaps(gap, b[7-i]);
            if (i == 7) expect_evt(v, fd, 1'b0, data, 1'b1);
            drive(1'b1, (i == 0) ? s_first : 1'b0, b[7-i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ch_data"},    ch_data,           32'h0);
        chk({tag, "_ch_valid"},   32'(ch_valid),     32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done),   32'h0);
        chk({tag, "_sync_err"},   32'(sync_err),     32'h0);
        chk({tag, "_locked"},     32'(locked),       32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        bit_en  = 1'b0;
        sync    = 1'b0;
        din     = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        check_reset_state("rst");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Basic frame A5,3C,0F,F0
        send_bits(8'hA5, 1, 1'b1, 0);
        chk("locked_after_sync", 32'(locked), 32'h1);
        for (int i = 1; i < 7; i++) drive(1'b1, 1'b0, ((8'hA5 >> (7-i)) & 8'h1) != 0);
        expect_evt(4'b0001, 1'b0, 1'b0, 32'h000000A5, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        send_slot(8'h3C, 1'b0, 4'b0010, 1'b0, 32'h00003CA5, 0);
        send_slot(8'h0F, 1'b0, 4'b0100, 1'b0, 32'h000F3CA5, 0);
        send_slot(8'hF0, 1'b0, 4'b1000, 1'b1, 32'hF00F3CA5, 0);

        // Back-to-back frame 11,22,33,44
        send_slot(8'h11, 1'b1, 4'b0001, 1'b0, 32'hF00F3C11, 0);
        send_slot(8'h22, 1'b0, 4'b0010, 1'b0, 32'hF00F2211, 0);
        send_slot(8'h33, 1'b0, 4'b0100, 1'b0, 32'hF0332211, 0);
        send_slot(8'h44, 1'b0, 4'b1000, 1'b1, 32'h44332211, 0);
        chk("locked_b2b", 32'(locked), 32'h1);

        // Missing sync at the frame boundary, then 32 unsynced bits ignored
        expect_evt(4'b0000, 1'b0, 1'b1, 32'h44332211, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, i[0]);
        chk("locked_after_miss", 32'(locked), 32'h0);
        chk("ch_data_hold_miss", ch_data, 32'h44332211);

        // Re-acquire, then early sync mid slot 1 re-frames onto byte 5A
        send_slot(8'hA5, 1'b1, 4'b0001, 1'b0, 32'h443322A5, 0);
        send_bits(8'h3C, 4, 1'b0, 0);
        expect_evt(4'b0000, 1'b0, 1'b1, 32'h443322A5, 1'b1);
        send_slot(8'h5A, 1'b1, 4'b0001, 1'b0, 32'h4433225A, 0);
        send_slot(8'h3C, 1'b0, 4'b0010, 1'b0, 32'h44333C5A, 0);
        send_slot(8'h0F, 1'b0, 4'b0100, 1'b0, 32'h440F3C5A, 0);
        send_slot(8'hF0, 1'b0, 4'b1000, 1'b1, 32'hF00F3C5A, 0);

        // Gapped strobe: bit_en every 3rd cycle
        send_slot(8'hA5, 1'b1, 4'b0001, 1'b0, 32'hF00F3CA5, 2);
        send_slot(8'h3C, 1'b0, 4'b0010, 1'b0, 32'hF00F3CA5, 2);
        send_slot(8'h0F, 1'b0, 4'b0100, 1'b0, 32'hF00F3CA5, 2);
        send_slot(8'hF0, 1'b0, 4'b1000, 1'b1, 32'hF00F3CA5, 2);
        gaps(2, 1'b0);

        // Reset mid-frame
        send_slot(8'h11, 1'b1, 4'b0001, 1'b0, 32'hF00F3C11, 0);
        send_bits(8'h22, 3, 1'b0, 0);
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        reset_n = 1'b1;
        check_reset_state("midrst");
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1);
        chk("locked_no_reacq", 32'(locked), 32'h0);
        send_slot(8'h11, 1'b1, 4'b0001, 1'b0, 32'h00000011, 0);
        send_slot(8'h22, 1'b0, 4'b0010, 1'b0, 32'h00002211, 0);
        send_slot(8'h33, 1'b0, 4'b0100, 1'b0, 32'h00332211, 0);
        send_slot(8'h44, 1'b0, 4'b1000, 1'b1, 32'h44332211, 0);

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
        chk("events_outstanding", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux4_rx.md
# tdm_demux4_rx

Receive-side counterpart of the 4:1 shared-line selector: recovers four channels from a single time-division-multiplexed serial line. Each frame carries four slots of `W` bits, slot 0 first and MSB first, marked by a frame-sync strobe. The block locks to the sync and shifts in the bits. At the end of each slot it writes the assembled word into that channel's output register and pulses the channel's valid flag. It sits between the shared bus line and the per-channel consumers.

## Interface
- `W`, default 8: bits per slot (channel word width), W ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `bit_en`  in  1  bit strobe; `din` and `sync` are sampled only on cycles with `bit_en`=1.
- `din`  in  1  serial data from the shared line.
- `sync`  in  1  frame marker; high with the first bit (slot 0 MSB) of every frame.
- `ch_data`  out  4*W  channel words; channel k at `[k*W+W-1 : k*W]`; registered, holds until overwritten.
- `ch_valid`  out  4  one-cycle pulse per channel when its word is updated.
- `frame_done`  out  1  one-cycle pulse when slot 3 completes.
- `sync_err`  out  1  one-cycle pulse on a missing or misplaced sync.
- `locked`  out  1  high while in RUN.

## Operation
- State: 2-state FSM (IDLE, RUN), `bit_cnt` (0..W-1), `slot_cnt` (0..3), W-1-bit shift register.
- Reset, when `reset_n`=0 at a clock edge:
  - FSM → IDLE, counters 0, shift register 0.
  - All outputs 0: `ch_data`, `ch_valid`, `frame_done`, `sync_err`, `locked`.
  - Reset overrides any frame in progress; the partial word is discarded.
- IDLE: hunts for sync.
  - On an enabled cycle with `sync`=1, `din` is taken as slot 0 bit W-1. Next state RUN, `bit_cnt`=1, `slot_cnt`=0.
  - Enabled cycles with `sync`=0 are ignored; no error is flagged.
- RUN: each enabled cycle shifts `din` in and increments `bit_cnt`.
  - On the enabled cycle with `bit_cnt`=W-1, the word `{shift, din}` is written to the channel selected by `slot_cnt`, and `ch_valid[slot_cnt]` pulses.
  - `bit_cnt` wraps to 0 and `slot_cnt` increments, wrapping 3→0.
  - At the slot-3 wrap, `frame_done` pulses together with `ch_valid[3]`.
- Sync checking in RUN, on enabled cycles only:
  - Frame boundary (`bit_cnt`=0, `slot_cnt`=0) with `sync`=1: normal. The bit is slot 0 MSB.
  - Frame boundary with `sync`=0: `sync_err` pulses, FSM → IDLE, `locked` drops, the bit is discarded. No `ch_valid` pulses until the next sync.
  - `sync`=1 at any other position: `sync_err` pulses and the partial word is discarded with no `ch_valid`. The current bit is taken as slot 0 MSB (`bit_cnt`=1, `slot_cnt`=0) and the FSM stays in RUN with `locked` held high. Channels already written this frame keep their values.
- Cycles with `bit_en`=0: no state change. Pulses are never generated on these cycles.

## Timing
- All outputs are registered.
- `ch_data` update and `ch_valid` pulse both appear 1 clk after the enabled clock edge that samples a slot's last bit.
- `locked` rises 1 clk after sync is accepted in IDLE. It falls 1 clk after the missing-sync cycle, coincident with `sync_err`.
- `sync_err`, `ch_valid` and `frame_done` are each high for exactly one clk.
- With `bit_en` tied high: frame period is 4W clks. Back-to-back frames require `sync` on every 4W-th cycle.
- Throughput: one bit per enabled cycle; no back-pressure.

## Test plan
- Basic frame: W=8, `bit_en`=1, sync at cycle 0 with bytes A5,3C,0F,F0. Expect:
  - `ch_valid[0]` at cycle 8, `[1]` at 16, `[2]` at 24, `[3]` with `frame_done` at 32.
  - `ch_data`=F00F3CA5 (ch3..ch0); `locked`=1 from cycle 1.
- Back-to-back: second frame 11,22,33,44 with sync at cycle 32. Expect no `sync_err`, `locked` stays 1, `ch_data`=44332211 after cycle 64.
- Missing sync: frame 1 normal, `sync`=0 at cycle 32. Expect:
  - `sync_err` and `locked`=0 at cycle 33.
  - No `ch_valid` for the following 32 bits; `ch_data` holds F00F3CA5.
- Early sync: `sync`=1 at cycle 12 (mid slot 1). Expect:
  - `sync_err` at cycle 13, no `ch_valid[1]` for the partial word, `ch0` keeps A5.
  - Re-framed slot 0 completes with `ch_valid[0]` at cycle 20.
- Gapped strobe: `bit_en` high every 3rd cycle, same frame as the basic test. Expect identical `ch_data`; each `ch_valid` 1 clk after the enabled cycle carrying that slot's LSB.
- Reset mid-frame: `reset_n`=0 for one edge at cycle 20. Expect all outputs 0 and `locked`=0 on the next cycle; the FSM re-acquires only on a new sync.
